relu_pool_out: RTL



---
 rtl/relu_pool_pkg.sv | 28 ++
 rtl/relu_pool_out_line_buf.sv | 22 ++
 rtl/relu_pool_out.sv | 132 +++++++++++++
 3 files changed

// File: rtl/relu_pool_pkg.sv
// Shared widths, packet helpers and FSM state encoding for the ReLU/max-pool output stage.
package relu_pool_pkg;
    localparam int NODE_W  = 5;
    localparam int PKT_W   = 20;
    localparam int PW      = PKT_W - 2 * NODE_W;
    localparam int SUM_LSB = 0;
    localparam int DST_LSB = PW;
    localparam int SRC_LSB = PW + NODE_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [PKT_W-1:0] pack_pkt(input logic [NODE_W-1:0] src,
                                                  input logic [NODE_W-1:0] dst,
                                                  input logic [PW-1:0]     val);
        return {src, dst, val};
    endfunction

    // Routing header is not needed downstream of the adder node.
    function automatic logic signed [PW-1:0] unpack_sum(input logic [PKT_W-1:0] pkt);
        logic [2*NODE_W-1:0] hdr_unused;
        hdr_unused = pkt[DST_LSB +: 2*NODE_W];
        return pkt[SUM_LSB +: PW];
    endfunction

    function automatic logic [PW-1:0] umax(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/relu_pool_out_line_buf.sv
// Pooling line buffer: holds the row-pair maxima of the even row, one entry per column pair.
module pool_line_buf #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int PW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [PW-1:0] i_wdata,
    output logic [PW-1:0] o_rdata
);
    logic [PW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/relu_pool_out.sv
// ReLU + 2x2/stride-2 max pooling of raster-ordered sums; emits pooled packets to the output memory node.
//   state | meaning
//   IDLE  | waiting for a layer configuration
//   RUN   | accepting raster sums, pooling
//   DRAIN | last sum taken, waiting for the output register to empty
//   DONE  | one-cycle end-of-layer pulse
module relu_pool_out
    import relu_pool_pkg::*;
#(
    parameter int              WIDTH      = 5,
    parameter int              DATA_WIDTH = 20,
    parameter int              MAX_W      = 16,
    parameter logic [WIDTH-1:0] NODE_INDEX = 5'd0,
    parameter logic [WIDTH-1:0] MEM_INDEX  = 5'd1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [$clog2(MAX_W):0]      cfg_w,
    input  logic [$clog2(MAX_W):0]      cfg_h,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_WIDTH-1:0]       in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        done
);
    localparam int CW = $clog2(MAX_W) + 1;
    localparam int AW = $clog2(MAX_W / 2);

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_w, r_h, r_col, r_row;
    logic [PW-1:0]         r_hold;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  w_cfg_hs, w_cfg_ok, w_in_hs, w_in_win, w_col_wrap, w_last;
    logic                  w_lb_we, w_load;
    logic signed [PW-1:0]  w_sum;
    logic [PW-1:0]         w_relu, w_lb_rd, w_pair;
    logic [CW-1:0]         w_w_even, w_h_even;

    assign cfg_ready = (r_state == IDLE);
    assign in_ready  = (r_state == RUN) && (!r_out_valid || out_ready);
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign done      = (r_state == DONE);

    assign w_cfg_hs = cfg_valid && cfg_ready;
    assign w_cfg_ok = (cfg_w >= CW'(2)) && (cfg_h >= CW'(2)) &&
                      (cfg_w <= CW'(MAX_W)) && (cfg_h <= CW'(MAX_W));
    assign w_in_hs  = in_valid && in_ready;

    assign w_sum  = unpack_sum(in_data);
    assign w_relu = w_sum[PW-1] ? '0 : $unsigned(w_sum);

    // Odd trailing row/column falls outside the window and is only consumed.
    assign w_w_even   = {r_w[CW-1:1], 1'b0};
    assign w_h_even   = {r_h[CW-1:1], 1'b0};
    assign w_in_win   = (r_col < w_w_even) && (r_row < w_h_even);
    assign w_col_wrap = (r_col == r_w - CW'(1));
    assign w_last     = w_col_wrap && (r_row == r_h - CW'(1));

    assign w_pair  = umax(r_hold, w_relu);
    assign w_lb_we = w_in_hs && w_in_win && !r_row[0] && r_col[0];
    assign w_load  = w_in_hs && w_in_win && r_row[0] && r_col[0];

    pool_line_buf #(.DEPTH(MAX_W / 2), .AW(AW), .PW(PW)) u_line_buf (
        .clk    (clk),
        .i_we   (w_lb_we),
        .i_addr (r_col[AW:1]),
        .i_wdata(w_pair),
        .o_rdata(w_lb_rd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cfg_hs) w_state_nxt = w_cfg_ok ? RUN : DONE;
            RUN:     if (w_in_hs && w_last) w_state_nxt = DRAIN;
            DRAIN:   if (!r_out_valid) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_w         <= '0;
            r_h         <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_hold      <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_cfg_hs) begin
                r_w   <= cfg_w;
                r_h   <= cfg_h;
                r_col <= '0;
                r_row <= '0;
            end
            if (w_in_hs) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= r_row + CW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                if (w_in_win && !r_col[0]) begin
                    r_hold <= r_row[0] ? umax(w_lb_rd, w_relu) : w_relu;
                end
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= pack_pkt(NODE_INDEX, MEM_INDEX, w_pair);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
